// File: rtl/data_mem_ctrl_pkg.sv
// rtl/data_mem_ctrl_pkg.sv - shared size encodings, FSM states and lane helper for data_mem_ctrl
package data_mem_ctrl_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_BYTE = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD    = 3'd1,
        WAITD = 3'd2,
        WR    = 3'd3,
        DONE  = 3'd4
    } state_e;

    // Bit offset of the addressed lane inside the 32-bit word (little-endian).
    function automatic logic [4:0] lane_shift(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: lane_shift = {off, 3'b000};
            SZ_HALF: lane_shift = {off[1], 4'b0000};
            default: lane_shift = 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_ctrl_lane.sv
// rtl/data_mem_ctrl_lane.sv - combinational lane extract/extend, store merge and alignment check
module mem_lane_unit
    import data_mem_ctrl_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o,
    output logic        align_err_o
);

    logic [4:0]  shift;
    logic [31:0] sh;
    logic [31:0] mask;

    assign shift = lane_shift(size_i, off_i);
    assign sh    = word_i >> shift;

    always_comb begin
        load_o = sh;
        mask   = 32'hFFFF_FFFF;
        case (size_i)
            SZ_BYTE: begin
                load_o = {{24{signed_i & sh[7]}}, sh[7:0]};
                mask   = 32'h0000_00FF;
            end
            SZ_HALF: begin
                load_o = {{16{signed_i & sh[15]}}, sh[15:0]};
                mask   = 32'h0000_FFFF;
            end
            default: ;
        endcase
    end

    assign merge_o = (word_i & ~(mask << shift)) | ((wdata_i << shift) & (mask << shift));

    assign align_err_o = (size_i == 2'b11)
                       || ((size_i == SZ_HALF) && off_i[0])
                       || ((size_i == SZ_WORD) && (off_i != 2'b00));

endmodule

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - MEM-stage load/store sequencer; DATA_MEM_CTRL_DEBUG_PORT_EN adds a debug read port
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic              ack,
    output logic [31:0]       rdata,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
`ifdef DATA_MEM_CTRL_DEBUG_PORT_EN
    ,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [31:0]       dbg_rdata,
    output logic              dbg_ack
`endif
);

    state_e      state_q;
    logic        write_q, signed_q;
    logic [1:0]  size_q, off_q;
    logic [31:0] wdata_q;

    logic        ack_q, err_q, mem_re_q, mem_we_q;
    logic [31:0] rdata_q, mem_wdata_q;
    logic [ADDR_W-1:0] mem_addr_q;

    logic        idle, grant_pipe, serving_dbg;
    logic        range_err, align_err, req_err;
    logic [1:0]  lane_size, lane_off;
    logic        lane_signed;
    logic [31:0] load_word, merge_word;

    assign idle = (state_q == IDLE);

`ifdef DATA_MEM_CTRL_DEBUG_PORT_EN
    logic        last_grant_q;  // 1 = debug was granted last
    logic        is_dbg_q, dbg_ack_q, grant_dbg;
    logic [31:0] dbg_rdata_q;

    assign grant_dbg   = dbg_req && (!req_valid || !last_grant_q);
    assign grant_pipe  = req_valid && !grant_dbg;
    assign serving_dbg = is_dbg_q;
    assign dbg_rdata   = dbg_rdata_q;
    assign dbg_ack     = dbg_ack_q;
`else
    assign grant_pipe  = req_valid;
    assign serving_dbg = 1'b0;
`endif

    // Lane unit sees the live request while deciding in IDLE, the latched one afterwards.
    assign lane_size   = idle ? req_size     : size_q;
    assign lane_off    = idle ? req_addr[1:0] : off_q;
    assign lane_signed = idle ? req_signed   : signed_q;

    mem_lane_unit u_lane (
        .size_i      (lane_size),
        .signed_i    (lane_signed),
        .off_i       (lane_off),
        .word_i      (mem_rdata),
        .wdata_i     (wdata_q),
        .load_o      (load_word),
        .merge_o     (merge_word),
        .align_err_o (align_err)
    );

    assign range_err = |(req_addr >> (ADDR_W + 2));
    assign req_err   = align_err || range_err;

    assign stall = serving_dbg ? req_valid
                 : ((idle && req_valid) || (state_q == RD) || (state_q == WAITD) || (state_q == WR));

    assign ack       = ack_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign mem_re    = mem_re_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            write_q     <= 1'b0;
            signed_q    <= 1'b0;
            size_q      <= SZ_WORD;
            off_q       <= 2'b00;
            wdata_q     <= 32'd0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= 32'd0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
`ifdef DATA_MEM_CTRL_DEBUG_PORT_EN
            last_grant_q <= 1'b1;
            is_dbg_q     <= 1'b0;
            dbg_ack_q    <= 1'b0;
            dbg_rdata_q  <= 32'd0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_pipe) begin
                        write_q  <= req_write;
                        signed_q <= req_signed;
                        size_q   <= req_size;
                        off_q    <= req_addr[1:0];
                        wdata_q  <= req_wdata;
`ifdef DATA_MEM_CTRL_DEBUG_PORT_EN
                        last_grant_q <= 1'b0;
`endif
                        if (req_err) begin
                            state_q <= DONE;
                            ack_q   <= 1'b1;
                            err_q   <= 1'b1;
                            rdata_q <= 32'd0;
                        end else if (req_write && (req_size == SZ_WORD)) begin
                            state_q     <= WR;
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= req_addr[ADDR_W+1:2];
                            mem_wdata_q <= req_wdata;
                        end else begin
                            state_q    <= RD;
                            mem_re_q   <= 1'b1;
                            mem_addr_q <= req_addr[ADDR_W+1:2];
                        end
                    end
`ifdef DATA_MEM_CTRL_DEBUG_PORT_EN
                    else if (grant_dbg) begin
                        last_grant_q <= 1'b1;
                        is_dbg_q     <= 1'b1;
                        state_q      <= RD;
                        mem_re_q     <= 1'b1;
                        mem_addr_q   <= dbg_addr;
                    end
`endif
                end
                RD: begin
                    mem_re_q <= 1'b0;
                    state_q  <= WAITD;
                end
                WAITD: begin
`ifdef DATA_MEM_CTRL_DEBUG_PORT_EN
                    if (is_dbg_q) begin
                        dbg_rdata_q <= mem_rdata;
                        dbg_ack_q   <= 1'b1;
                        state_q     <= DONE;
                    end else
`endif
                    if (!write_q) begin
                        rdata_q <= load_word;
                        ack_q   <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        mem_we_q    <= 1'b1;
                        mem_wdata_q <= merge_word;
                        state_q     <= WR;
                    end
                end
                WR: begin
                    mem_we_q <= 1'b0;
                    ack_q    <= 1'b1;
                    state_q  <= DONE;
                end
                DONE: begin
                    ack_q   <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= IDLE;
`ifdef DATA_MEM_CTRL_DEBUG_PORT_EN
                    dbg_ack_q <= 1'b0;
                    is_dbg_q  <= 1'b0;
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - self-checking bench for data_mem_ctrl against a byte-level reference model
module tb_data_mem_ctrl;

    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid, req_write, req_signed;
    logic [1:0]        req_size;
    logic [31:0]       req_addr, req_wdata;
    logic              stall, ack, err, mem_re, mem_we;
    logic [31:0]       rdata, mem_wdata, mem_rdata;
    logic [ADDR_W-1:0] mem_addr;
`ifdef DATA_MEM_CTRL_DEBUG_PORT_EN
    logic              dbg_req, dbg_ack;
    logic [ADDR_W-1:0] dbg_addr;
    logic [31:0]       dbg_rdata;
`endif

    int checks = 0;
    int failures = 0;

    logic [31:0] env_mem [0:31];
    logic [7:0]  ref_bytes [0:127];

    always #5 clk = ~clk;

    data_mem_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
        .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .ack(ack), .rdata(rdata), .err(err),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef DATA_MEM_CTRL_DEBUG_PORT_EN
        , .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack)
`endif
    );

    // Synchronous-read word memory the controller drives.
    always @(posedge clk) begin
        if (mem_we) env_mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= env_mem[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_word(input int w);
        logic [31:0] v;
        for (int i = 0; i < 4; i++) v[8*i +: 8] = ref_bytes[4*w + i];
        return v;
    endfunction

    // lk: 0 no literal, 1 literal is the load result, 2 literal is the written word
    task automatic access(input bit wr, input logic [1:0] sz, input bit sg, input logic [31:0] a,
                          input logic [31:0] wd, input int lk, input logic [31:0] lit);
        int nb, lat;
        bit e, rd_needed;
        logic [31:0] exp_rd, exp_word;
        nb = (sz == 2'd0) ? 4 : (sz == 2'd1) ? 1 : 2;
        e = (sz == 2'd3) || ((a & (nb - 1)) != 0) || (a >= 32'd128);
        exp_rd = 32'd0;
        exp_word = 32'd0;
        if (!e) begin
            if (wr) begin
                for (int i = 0; i < nb; i++) ref_bytes[a + i] = wd[8*i +: 8];
            end else begin
                for (int i = 0; i < nb; i++) exp_rd[8*i +: 8] = ref_bytes[a + i];
                if (sg && nb < 4 && exp_rd[8*nb-1])
                    for (int b = 8*nb; b < 32; b++) exp_rd[b] = 1'b1;
            end
            exp_word = ref_word(int'(a[6:2]));
        end
        lat = e ? 1 : (wr ? ((nb == 4) ? 2 : 4) : 3);
        rd_needed = !e && !(wr && nb == 4);

        req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
        for (int k = 0; k <= lat; k++) begin
            @(negedge clk);
            chk("stall", {31'd0, stall}, {31'd0, k < lat});
            chk("ack", {31'd0, ack}, {31'd0, k == lat});
            chk("mem_re", {31'd0, mem_re}, {31'd0, rd_needed && k == 1});
            chk("mem_we", {31'd0, mem_we}, {31'd0, !e && wr && k == lat - 1});
            if (mem_re || mem_we) chk("mem_addr", {27'd0, mem_addr}, {27'd0, a[6:2]});
            if (mem_we) begin
                chk("mem_wdata", mem_wdata, exp_word);
                if (lk == 2) chk("mem_wdata_lit", mem_wdata, lit);
            end
            if (k == lat) begin
                chk("err", {31'd0, err}, {31'd0, e});
                if (!wr || e) chk("rdata", rdata, exp_rd);
                if (lk == 1) chk("rdata_lit", rdata, lit);
            end
            if (k < lat) begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) env_mem[i] = 32'd0;
        for (int i = 0; i < 128; i++) ref_bytes[i] = 8'd0;
        rst_n = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0;
`ifdef DATA_MEM_CTRL_DEBUG_PORT_EN
        dbg_req = 1'b0; dbg_addr = '0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_strobes", {30'd0, mem_re, mem_we}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        access(1, 2'd0, 0, 32'h08, 32'hDEADBEEF, 2, 32'hDEADBEEF);
        access(0, 2'd0, 0, 32'h08, 32'h0,        1, 32'hDEADBEEF);
        access(1, 2'd0, 0, 32'h04, 32'h11223344, 0, 32'h0);
        access(1, 2'd1, 0, 32'h05, 32'h123456AA, 2, 32'h1122AA44);
        access(0, 2'd0, 0, 32'h04, 32'h0,        1, 32'h1122AA44);
        access(1, 2'd0, 0, 32'h08, 32'h0000F080, 0, 32'h0);
        access(0, 2'd1, 1, 32'h08, 32'h0,        1, 32'hFFFFFF80);
        access(0, 2'd2, 0, 32'h08, 32'h0,        1, 32'h0000F080);
        access(0, 2'd2, 1, 32'h0A, 32'h0,        1, 32'h00000000);
        access(1, 2'd2, 0, 32'h0A, 32'h0000BEEF, 2, 32'hBEEFF080);
        access(0, 2'd2, 1, 32'h0A, 32'h0,        1, 32'hFFFFBEEF);
        access(0, 2'd1, 0, 32'h0B, 32'h0,        1, 32'h000000BE);
        access(0, 2'd2, 0, 32'h03, 32'h0,        0, 32'h0);
        access(0, 2'd0, 0, 32'h06, 32'h0,        0, 32'h0);
        access(0, 2'd0, 0, 32'h80, 32'h0,        0, 32'h0);
        access(0, 2'd3, 0, 32'h00, 32'h0,        0, 32'h0);
        access(1, 2'd1, 0, 32'h84, 32'h000000FF, 0, 32'h0);
        access(0, 2'd0, 0, 32'h04, 32'h0,        1, 32'h1122AA44);

        // Abort a byte store in WAITD: memory must stay untouched.
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd1; req_signed = 1'b0;
        req_addr = 32'h06; req_wdata = 32'h000000CC;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2;
        rst_n = 1'b0; req_valid = 1'b0;
        #1;
        chk("abort_strobes", {30'd0, mem_re, mem_we}, 32'd0);
        chk("abort_ack", {31'd0, ack}, 32'd0);
        chk("abort_stall", {31'd0, stall}, 32'd0);
        chk("abort_addr", {27'd0, mem_addr}, 32'd0);
        chk("abort_wdata", mem_wdata, 32'd0);
        chk("abort_rdata", rdata, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("abort_no_ack", {29'd0, ack, mem_re, mem_we}, 32'd0);
        end
        chk("abort_mem", env_mem[1], 32'h1122AA44);
        @(posedge clk); #1;
        access(0, 2'd0, 0, 32'h04, 32'h0, 1, 32'h1122AA44);

`ifdef DATA_MEM_CTRL_DEBUG_PORT_EN
        begin
            string seq;
            int n;
            seq = "";
            n = 0;
            req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0; req_addr = 32'h04;
            req_valid = 1'b1; dbg_req = 1'b1; dbg_addr = 5'd2;
            for (int c = 0; c < 40 && n < 3; c++) begin
                @(negedge clk);
                if (ack) begin
                    seq = {seq, "P"}; n++;
                    chk("arb_rdata", rdata, ref_word(1));
                end else begin
                    chk("arb_stall", {31'd0, stall}, 32'd1);
                end
                if (dbg_ack) begin
                    seq = {seq, "D"}; n++;
                    chk("dbg_rdata", dbg_rdata, ref_word(2));
                    chk("dbg_rdata_lit", dbg_rdata, 32'hBEEFF080);
                end
                @(posedge clk); #1;
            end
            req_valid = 1'b0; dbg_req = 1'b0;
            checks++;
            if (seq != "PDP") begin
                failures++;
                $display("FAIL arb_order actual=%s expected=PDP", seq);
            end
        end
`endif

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
